mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Parametrised MEM pipeline stage: replaces single-cycle DataMem access with a req/ack data-bus
//  master, posted-store buffer, load sign/zero extension, misalignment detection and registered
//  branch resolution. Sits between execute and write-back; stalls execute via in_ready.
// PARAMETERS
//  XLEN      32  data/address width (PC, imm32, Rdata2, ALU_result, DataWord)
//  SB_DEPTH  4   store-buffer entries (power of 2, >=2)
// PORTS
//  clk               in   1     clock
//  rst               in   1     synchronous active-high reset
//  in_valid          in   1     execute-stage op present
//  in_ready          out  1     stage accepts op this cycle (transfer = in_valid & in_ready)
//  mem_wEn/mem_rEn   in   1     store / load op (both 0 = pass-through)
//  load_extend_sign  in   1     1 = sign-extend sub-word loads
//  branch_op         in   1     op is a conditional branch
//  MemSize           in   2     00 byte, 01 half, 10/11 word
//  PC, imm32, Rdata2, ALU_result  in  XLEN  as from execute stage
//  out_valid         out  1     one-cycle result strobe to write-back
//  DataWord          out  XLEN  load data (extended) or ALU_result pass-through
//  branch_jump_flag  out  1     branch_op & ALU_result[0], valid with out_valid
//  branch_target_pc  out  XLEN  PC+imm32 if taken, else 0
//  misalign_err      out  1     misaligned access, valid with out_valid
//  sb_empty          out  1     store buffer empty (for fences)
//  dm_req/dm_we      out  1     bus request / write
//  dm_addr, dm_wdata out  XLEN  word-aligned address; store data replicated to lanes
//  dm_be             out  4*    byte enables (XLEN/8)
//  dm_ack            in   1     transaction complete; dm_rdata valid this cycle
//  dm_rdata          in   XLEN  read data
// BEHAVIOUR
//  - Reset: all outputs 0 except in_ready=1, sb_empty=1; FSM IDLE; SB cleared; abandons any bus op.
//  - FSM IDLE/LOAD/STORE. dm_req and all dm_* held stable from issue until dm_ack; one op at a time.
//  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0 -> no bus op, not buffered;
//    out_valid next cycle, misalign_err=1, DataWord=0.
//  - Pass-through/branch: out_valid next cycle, DataWord=ALU_result.
//  - Store: accepted if SB not full; enqueued {addr,be,wdata}; out_valid next cycle. SB full ->
//    in_ready=0. Enqueue+dequeue same cycle: count unchanged, legal when full.
//  - Load: in_ready=0 until done. Hazard = any SB entry with same word address. Bus arbitration in
//    IDLE: non-hazard pending load first, else drain SB head (FIFO order). Load result: out_valid the
//    cycle after dm_ack (min 2 cycles).
//  - Extension: byte lane addr[1:0], half lane addr[1]; pad with sign bit if load_extend_sign else 0.
//  - dm_ack while IDLE ignored. out_valid never high two ops back-to-back without new acceptance.
// CONFIGURATION
//  STORE_FWD_EN defined: load whose youngest matching SB entry has be=4'b1111 takes data from that
//   entry, no bus op, out_valid next cycle; partial-overlap hits still wait for drain.
//  Undefined: any hazard blocks the load until all matching entries drained.
// TESTING
//  - Store 0xDEADBEEF @0x100, then word load @0x104 -> load issues before drain, out_valid 2 cyc after issue.
//  - Byte load @0x103, rdata 0x80FF_FF_FF, sign=1 -> 0xFFFFFF80; sign=0 -> 0x00000080.
//  - 5 back-to-back stores, dm_ack withheld, SB_DEPTH=4 -> 5th sees in_ready=0 until first ack.
//  - Half load @0x101 -> misalign_err=1, DataWord=0, dm_req never asserted.
//  - Store 0x12345678 @0x200 then load @0x200: FWD_EN -> 0x12345678 in 1 cycle; else after drain.
//  - Branch PC=0x40 imm=0x10 ALU_result=1 -> flag=1, target 0x50; rst mid-load -> dm_req=0 next cycle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM stage with req/ack bus master, posted-store buffer, load extension and misalign detect.
// Define STORE_FWD_EN to forward full-word buffered stores to matching loads.
module mem_access_ctrl #(
   parameter int XLEN     = 32,
   parameter int SB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              mem_wEn,
   input  logic              mem_rEn,
   input  logic              load_extend_sign,
   input  logic              branch_op,
   input  logic [1:0]        MemSize,
   input  logic [XLEN-1:0]   PC,
   input  logic [XLEN-1:0]   imm32,
   input  logic [XLEN-1:0]   Rdata2,
   input  logic [XLEN-1:0]   ALU_result,
   output logic              out_valid,
   output logic [XLEN-1:0]   DataWord,
   output logic              branch_jump_flag,
   output logic [XLEN-1:0]   branch_target_pc,
   output logic              misalign_err,
   output logic              sb_empty,
   output logic              dm_req,
   output logic              dm_we,
   output logic [XLEN-1:0]   dm_addr,
   output logic [XLEN-1:0]   dm_wdata,
   output logic [XLEN/8-1:0] dm_be,
   input  logic              dm_ack,
   input  logic [XLEN-1:0]   dm_rdata
);
   localparam int BW = XLEN / 8;
   localparam int AW = $clog2(SB_DEPTH);
   localparam int CW = $clog2(SB_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;
   state_t state, state_nx;

   logic [XLEN-1:0] sb_addr [SB_DEPTH];
   logic [BW-1:0]   sb_be   [SB_DEPTH];
   logic [XLEN-1:0] sb_data [SB_DEPTH];
   logic [AW-1:0]   head, tail, fidx;
   logic [CW-1:0]   cnt;
   logic            ld_pend, ld_sign;
   logic [1:0]      ld_size;
   logic [XLEN-1:0] ld_addr, lq_addr, st_wdata;
   logic [BW-1:0]   st_be;
   logic            is_st, is_ld, mis, sb_full, deq, enq, acc, inc_ld, fwd, lq_valid, haz;
   logic            issue_ld, issue_st, ld_done;

   function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] d, input logic [1:0] a,
                                           input logic [1:0] sz, input logic s);
      logic [7:0]  b;
      logic [15:0] h;
      b   = d[{a, 3'b000} +: 8];
      h   = d[{a[1], 4'b0000} +: 16];
      ext = sz == 2'b00 ? {{(XLEN-8){s & b[7]}}, b} :
            sz == 2'b01 ? {{(XLEN-16){s & h[15]}}, h} : d;
   endfunction

   assign is_st    = mem_wEn;
   assign is_ld    = mem_rEn & ~mem_wEn;
   assign mis      = (is_st | is_ld) &
                     ((MemSize == 2'b01 & ALU_result[0]) | (MemSize[1] & |ALU_result[1:0]));
   assign sb_full  = cnt == CW'(SB_DEPTH);
   assign sb_empty = cnt == '0;
   assign deq      = state == STORE & dm_ack;
   assign ld_done  = state == LOAD & dm_ack;
   assign in_ready = ~ld_pend & ~(is_st & ~mis & sb_full & ~deq);
   assign acc      = in_valid & in_ready;
   assign enq      = acc & is_st & ~mis;
   assign inc_ld   = acc & is_ld & ~mis;
   assign lq_addr  = ld_pend ? ld_addr : ALU_result;
   assign lq_valid = ld_pend | (inc_ld & ~fwd);
   assign st_be    = MemSize == 2'b00 ? BW'(1) << ALU_result[1:0] :
                     MemSize == 2'b01 ? BW'(3) << {ALU_result[1], 1'b0} : '1;
   assign st_wdata = MemSize == 2'b00 ? {BW{Rdata2[7:0]}} :
                     MemSize == 2'b01 ? {(XLEN/16){Rdata2[15:0]}} : Rdata2;

   // scan oldest to youngest so fidx ends on the youngest word-address match
   always_comb begin
      haz  = 1'b0;
      fidx = '0;
      for (int i = 0; i < SB_DEPTH; i++)
         if (CW'(i) < cnt && sb_addr[head + AW'(i)][XLEN-1:2] == lq_addr[XLEN-1:2]) begin
            haz  = 1'b1;
            fidx = head + AW'(i);
         end
   end

`ifdef STORE_FWD_EN
   assign fwd = inc_ld & haz & (&sb_be[fidx]);
`else
   assign fwd = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      issue_ld = 1'b0;
      issue_st = 1'b0;
      if (state == IDLE) begin
         issue_ld = lq_valid & ~haz;
         issue_st = ~issue_ld & ~sb_empty;
         state_nx = issue_ld ? LOAD : issue_st ? STORE : IDLE;
      end else if (dm_ack)
         state_nx = IDLE;
   end

   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt              <= '0;
         head             <= '0;
         tail             <= '0;
         ld_pend          <= 1'b0;
         ld_sign          <= 1'b0;
         ld_size          <= '0;
         ld_addr          <= '0;
         dm_req           <= 1'b0;
         dm_we            <= 1'b0;
         dm_addr          <= '0;
         dm_wdata         <= '0;
         dm_be            <= '0;
         out_valid        <= 1'b0;
         DataWord         <= '0;
         branch_jump_flag <= 1'b0;
         branch_target_pc <= '0;
         misalign_err     <= 1'b0;
      end else begin
         cnt <= cnt + CW'(enq) - CW'(deq);
         if (enq) begin
            sb_addr[tail] <= {ALU_result[XLEN-1:2], 2'b00};
            sb_be[tail]   <= st_be;
            sb_data[tail] <= st_wdata;
            tail          <= tail + 1'b1;
         end
         if (deq) head <= head + 1'b1;
         if (inc_ld & ~fwd) begin
            ld_pend <= 1'b1;
            ld_addr <= ALU_result;
            ld_size <= MemSize;
            ld_sign <= load_extend_sign;
         end else if (ld_done)
            ld_pend <= 1'b0;
         if (issue_ld | issue_st) begin
            dm_req   <= 1'b1;
            dm_we    <= issue_st;
            dm_addr  <= issue_st ? sb_addr[head] : {lq_addr[XLEN-1:2], 2'b00};
            dm_be    <= issue_st ? sb_be[head] : '1;
            dm_wdata <= issue_st ? sb_data[head] : '0;
         end else if (state != IDLE & dm_ack) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
         end
         out_valid        <= (acc & ~(inc_ld & ~fwd)) | ld_done;
         misalign_err     <= acc & mis;
         branch_jump_flag <= acc & branch_op & ALU_result[0];
         branch_target_pc <= acc & branch_op & ALU_result[0] ? PC + imm32 : '0;
         if (ld_done)
            DataWord <= ext(dm_rdata, ld_addr[1:0], ld_size, ld_sign);
         else if (acc)
            DataWord <= mis ? '0 :
                        fwd ? ext(sb_data[fidx], ALU_result[1:0], MemSize, load_extend_sign) : ALU_result;
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vectors for mem_access_ctrl with a hand-driven data bus.
module tb_mem_access_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, mem_wEn = 1'b0, mem_rEn = 1'b0;
   logic        load_extend_sign = 1'b0, branch_op = 1'b0;
   logic [1:0]  MemSize = '0;
   logic [31:0] PC = '0, imm32 = '0, Rdata2 = '0, ALU_result = '0;
   logic        out_valid, branch_jump_flag, misalign_err, sb_empty;
   logic [31:0] DataWord, branch_target_pc, dm_addr, dm_wdata;
   logic        dm_req, dm_we, dm_ack = 1'b0;
   logic [3:0]  dm_be;
   logic [31:0] dm_rdata = '0;
   int          n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.XLEN(32), .SB_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mem_wEn(mem_wEn), .mem_rEn(mem_rEn), .load_extend_sign(load_extend_sign),
      .branch_op(branch_op), .MemSize(MemSize), .PC(PC), .imm32(imm32),
      .Rdata2(Rdata2), .ALU_result(ALU_result), .out_valid(out_valid),
      .DataWord(DataWord), .branch_jump_flag(branch_jump_flag),
      .branch_target_pc(branch_target_pc), .misalign_err(misalign_err),
      .sb_empty(sb_empty), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic w, input logic r, input logic sg, input logic br,
                        input logic [1:0] sz, input logic [31:0] alu, input logic [31:0] rd2,
                        input logic [31:0] pc, input logic [31:0] imm);
      in_valid = 1'b1; mem_wEn = w; mem_rEn = r; load_extend_sign = sg; branch_op = br;
      MemSize = sz; ALU_result = alu; Rdata2 = rd2; PC = pc; imm32 = imm;
   endtask

   task automatic idle_in();
      in_valid = 1'b0; mem_wEn = 1'b0; mem_rEn = 1'b0; branch_op = 1'b0;
   endtask

   // wait (bounded) for a bus request, check it, then ack it for one cycle
   task automatic serve(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] be, input logic [31:0] wdata, input logic [31:0] rdata);
      int t = 0;
      while (!dm_req && t < 50) begin
         @(negedge clk);
         t++;
      end
      check({tag, ".req"}, {31'd0, dm_req}, 32'd1);
      if (dm_req) begin
         check({tag, ".we"}, {31'd0, dm_we}, {31'd0, we});
         check({tag, ".addr"}, dm_addr, addr);
         if (we) begin
            check({tag, ".be"}, {28'd0, dm_be}, be);
            check({tag, ".wdata"}, dm_wdata, wdata);
         end
         dm_ack = 1'b1; dm_rdata = rdata;
         @(negedge clk);
         dm_ack = 1'b0;
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst.in_ready", {31'd0, in_ready}, 32'd1);
      check("rst.sb_empty", {31'd0, sb_empty}, 32'd1);
      check("rst.out_valid", {31'd0, out_valid}, 32'd0);
      check("rst.dm_req", {31'd0, dm_req}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      drive(0, 0, 0, 1, 2'b10, 32'h1, 32'h0, 32'h40, 32'h10);
      @(negedge clk); idle_in();
      check("br.valid", {31'd0, out_valid}, 32'd1);
      check("br.flag", {31'd0, branch_jump_flag}, 32'd1);
      check("br.target", branch_target_pc, 32'h50);
      check("br.data", DataWord, 32'h1);
      drive(0, 0, 0, 1, 2'b10, 32'h0, 32'h0, 32'h40, 32'h10);
      @(negedge clk); idle_in();
      check("brnt.flag", {31'd0, branch_jump_flag}, 32'd0);
      check("brnt.target", branch_target_pc, 32'h0);
      @(negedge clk);
      check("br.once", {31'd0, out_valid}, 32'd0);

      drive(0, 1, 1, 0, 2'b01, 32'h101, 32'h0, 32'h0, 32'h0);
      @(negedge clk); idle_in();
      check("mis.valid", {31'd0, out_valid}, 32'd1);
      check("mis.err", {31'd0, misalign_err}, 32'd1);
      check("mis.data", DataWord, 32'h0);
      @(negedge clk);
      check("mis.noreq", {31'd0, dm_req}, 32'd0);

      drive(0, 1, 1, 0, 2'b00, 32'h103, 32'h0, 32'h0, 32'h0);
      #1 check("lbs.ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk); idle_in();
      check("lbs.busy", {31'd0, in_ready}, 32'd0);
      serve("lbs", 0, 32'h100, 0, 0, 32'h80FFFFFF);
      check("lbs.valid", {31'd0, out_valid}, 32'd1);
      check("lbs.data", DataWord, 32'hFFFFFF80);
      drive(0, 1, 0, 0, 2'b00, 32'h103, 32'h0, 32'h0, 32'h0);
      @(negedge clk); idle_in();
      serve("lbu", 0, 32'h100, 0, 0, 32'h80FFFFFF);
      check("lbu.data", DataWord, 32'h00000080);

      drive(1, 0, 0, 0, 2'b10, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0);
      @(negedge clk);
      check("st.valid", {31'd0, out_valid}, 32'd1);
      drive(0, 1, 0, 0, 2'b10, 32'h104, 32'h0, 32'h0, 32'h0);
      #1 check("ld104.ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk); idle_in();
      check("ld104.pending", {31'd0, out_valid}, 32'd0);
      serve("ld104", 0, 32'h104, 0, 0, 32'hCAFEF00D);
      check("ld104.valid", {31'd0, out_valid}, 32'd1);
      check("ld104.data", DataWord, 32'hCAFEF00D);
      serve("st100", 1, 32'h100, 32'hF, 32'hDEADBEEF, 0);
      check("st100.empty", {31'd0, sb_empty}, 32'd1);

      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, 2'b10, 32'h300 + 4 * i, 32'h1000 + i, 32'h0, 32'h0);
         #1 check($sformatf("full.rdy%0d", i), {31'd0, in_ready}, 32'd1);
         @(negedge clk);
      end
      drive(1, 0, 0, 0, 2'b10, 32'h310, 32'h1004, 32'h0, 32'h0);
      #1 check("full.blk0", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check("full.blk1", {31'd0, in_ready}, 32'd0);
      check("full.noout", {31'd0, out_valid}, 32'd0);
      check("full.head", dm_addr, 32'h300);
      dm_ack = 1'b1;
      #1 check("full.deq", {31'd0, in_ready}, 32'd1);
      @(negedge clk); dm_ack = 1'b0; idle_in();
      check("full.valid", {31'd0, out_valid}, 32'd1);
      check("full.nonempty", {31'd0, sb_empty}, 32'd0);
      for (int i = 1; i < 5; i++)
         serve($sformatf("drain%0d", i), 1, 32'h300 + 4 * i, 32'hF, 32'h1000 + i, 0);
      check("drain.empty", {31'd0, sb_empty}, 32'd1);

      drive(1, 0, 0, 0, 2'b00, 32'h402, 32'hAB, 32'h0, 32'h0);
      @(negedge clk); idle_in();
      serve("sb", 1, 32'h400, 32'h4, 32'hABABABAB, 0);

      drive(1, 0, 0, 0, 2'b10, 32'h200, 32'h12345678, 32'h0, 32'h0);
      @(negedge clk);
      drive(0, 1, 0, 0, 2'b10, 32'h200, 32'h0, 32'h0, 32'h0);
      @(negedge clk); idle_in();
`ifdef STORE_FWD_EN
      check("fwd.valid", {31'd0, out_valid}, 32'd1);
      check("fwd.data", DataWord, 32'h12345678);
      serve("fwd.st", 1, 32'h200, 32'hF, 32'h12345678, 0);
`else
      check("haz.wait", {31'd0, out_valid}, 32'd0);
      serve("haz.st", 1, 32'h200, 32'hF, 32'h12345678, 0);
      serve("haz.ld", 0, 32'h200, 0, 0, 32'h12345678);
      check("haz.valid", {31'd0, out_valid}, 32'd1);
      check("haz.data", DataWord, 32'h12345678);
`endif
      @(negedge clk);
      check("haz.empty", {31'd0, sb_empty}, 32'd1);

      drive(0, 1, 0, 0, 2'b10, 32'h500, 32'h0, 32'h0, 32'h0);
      @(negedge clk); idle_in();
      check("rstld.req", {31'd0, dm_req}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rstld.drop", {31'd0, dm_req}, 32'd0);
      check("rstld.out", {31'd0, out_valid}, 32'd0);
      rst = 1'b0;
      #1 check("rstld.ready", {31'd0, in_ready}, 32'd1);
      dm_ack = 1'b1;
      @(negedge clk); dm_ack = 1'b0;
      @(negedge clk);
      check("stray.out", {31'd0, out_valid}, 32'd0);
      check("stray.req", {31'd0, dm_req}, 32'd0);
      check("stray.empty", {31'd0, sb_empty}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
